// File: rtl/local_access_pkg.sv
// Shared definitions for the HCP local access responder: bus widths,
// error-register constants, the read-pipeline stage record and the
// saturating increment used by the error counter.
package local_access_pkg;

    localparam int LA_ADDR_W = 19;
    localparam int LA_DATA_W = 32;
    localparam int ERR_CNT_W = 16;

    localparam logic [LA_ADDR_W-1:0] ERR_REG_ADDR = 19'd0;
    localparam logic [LA_DATA_W-1:0] OOR_RDATA    = 32'h0000_0000;

    // One read request travelling through stage 1 of the read pipeline.
    typedef struct packed {
        logic                 vld;
        logic [LA_ADDR_W-1:0] addr;
        logic                 fix;
        logic                 ok;
    } rd_stage_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (v == {ERR_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/local_access_responder_if.sv
// Local access bus between the HCP command dispatcher (master) and a
// register-side responder (slave). Request signals flow master->slave,
// the read response (o_* signals) flows slave->master.
interface local_access_responder_if;
    import local_access_pkg::*;

    logic                 i_wr;
    logic [LA_DATA_W-1:0] iv_wdata;
    logic [LA_ADDR_W-1:0] iv_addr;
    logic                 i_addr_fix;
    logic                 i_rd;

    logic                 o_wr;
    logic [LA_ADDR_W-1:0] ov_raddr;
    logic                 o_addr_fix;
    logic [LA_DATA_W-1:0] ov_rdata;

    modport master (
        output i_wr, iv_wdata, iv_addr, i_addr_fix, i_rd,
        input  o_wr, ov_raddr, o_addr_fix, ov_rdata
    );

    modport slave (
        input  i_wr, iv_wdata, iv_addr, i_addr_fix, i_rd,
        output o_wr, ov_raddr, o_addr_fix, ov_rdata
    );

endinterface

// File: rtl/lar_table_ram.sv
// Simple dual-port table RAM with registered reads on both ports.
// Port A is the local-bus write/read port, port B is the read-only
// datapath port. A port-B read of a word written in the same cycle
// returns the previous contents. Contents are not reset.
module lar_table_ram
    import local_access_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_a_we,
    input  logic [AW-1:0]        iv_a_addr,
    input  logic [LA_DATA_W-1:0] iv_a_wdata,
    output logic [LA_DATA_W-1:0] ov_a_rdata,
    input  logic [AW-1:0]        iv_b_addr,
    output logic [LA_DATA_W-1:0] ov_b_rdata
);

    logic [LA_DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [LA_DATA_W-1:0] a_rdata_q;
    logic [LA_DATA_W-1:0] b_rdata_q;

    // Storage write plus registered reads; nonblocking update gives old-data reads.
    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            mem_q[iv_a_addr] <= iv_a_wdata;
        end
        a_rdata_q <= mem_q[iv_a_addr];
        b_rdata_q <= mem_q[iv_b_addr];
    end

    assign ov_a_rdata = a_rdata_q;
    assign ov_b_rdata = b_rdata_q;

endmodule

// File: rtl/local_access_responder.sv
// Register-side responder for the HCP local access bus.
// Decodes writes/reads into REG_NUM fixed 32-bit registers (addr_fix=1)
// and a TBL_DEPTH-word table RAM (addr_fix=0). Reads answer with a fixed
// 2-cycle latency through a two-stage pipeline. Registers are exported
// on ov_cfg_regs, the table on a separate datapath read port.
// Optional feature: define LOCAL_ACCESS_ERR_CNT_EN to add the saturating
// error counter visible in register 0; without it register 0 reads zero.
module local_access_responder
    import local_access_pkg::*;
#(
    parameter int REG_NUM   = 16,
    parameter int TBL_DEPTH = 256,
    parameter int TBL_AW    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    local_access_responder_if.slave      bus,
    output logic [REG_NUM*LA_DATA_W-1:0] ov_cfg_regs,
    input  logic [TBL_AW-1:0]            iv_dp_tbl_addr,
    output logic [LA_DATA_W-1:0]         ov_dp_tbl_rdata
);

    localparam logic [LA_ADDR_W-1:0] REG_LIMIT = LA_ADDR_W'(REG_NUM);
    localparam logic [LA_ADDR_W-1:0] TBL_LIMIT = LA_ADDR_W'(TBL_DEPTH);
    localparam int                   IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic reg_hit_s;
    logic tbl_hit_s;
    logic in_range_s;
    logic reg_we_s;
    logic tbl_we_s;
    logic rd_acc_s;

    // Classify the current request by region, range and strobe combination.
    always_comb begin
        reg_hit_s = (bus.iv_addr < REG_LIMIT);
        tbl_hit_s = (bus.iv_addr < TBL_LIMIT);
        if (bus.i_addr_fix) begin
            in_range_s = reg_hit_s;
        end else begin
            in_range_s = tbl_hit_s;
        end
        reg_we_s = bus.i_wr & bus.i_addr_fix & reg_hit_s & (bus.iv_addr != ERR_REG_ADDR);
        tbl_we_s = bus.i_wr & ~bus.i_addr_fix & tbl_hit_s;
        // A read colliding with a write is a protocol error and is dropped.
        rd_acc_s = bus.i_rd & ~bus.i_wr;
    end

    // ------------------------------------------------------------------
    // Fixed register bank (register 0 is the error/status register)
    // ------------------------------------------------------------------
    logic [LA_DATA_W-1:0] regs_q [REG_NUM-1:1];
    logic [LA_DATA_W-1:0] err_reg_s;

    // Writable registers 1..REG_NUM-1; cleared on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 1; k < REG_NUM; k++) begin
                regs_q[k] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 1; k < REG_NUM; k++) begin
                if (reg_we_s && (bus.iv_addr == LA_ADDR_W'(k))) begin
                    regs_q[k] <= bus.iv_wdata;
                end
            end
        end
    end

`ifdef LOCAL_ACCESS_ERR_CNT_EN
    logic                 err_clr_s;
    logic                 err_evt_s;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    // Error-counter next state: clear beats any same-cycle error, at most +1 per cycle.
    always_comb begin
        err_clr_s = bus.i_wr & bus.i_addr_fix & (bus.iv_addr == ERR_REG_ADDR);
        err_evt_s = ((bus.i_wr | bus.i_rd) & ~in_range_s) | (bus.i_wr & bus.i_rd);
        if (err_clr_s) begin
            err_cnt_d = {ERR_CNT_W{1'b0}};
        end else if (err_evt_s) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error-counter state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_cnt_q <= {ERR_CNT_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_reg_s = {{(LA_DATA_W-ERR_CNT_W){1'b0}}, err_cnt_q};
`else
    assign err_reg_s = 32'h0000_0000;
`endif

    // Flat view of all registers, shared by the export bus and the read mux.
    logic [LA_DATA_W-1:0]         regs_all_s [0:REG_NUM-1];
    logic [REG_NUM*LA_DATA_W-1:0] cfg_s;

    // Collect register 0 and the writable bank into one packed export.
    always_comb begin
        regs_all_s[0]            = err_reg_s;
        cfg_s                    = {(REG_NUM*LA_DATA_W){1'b0}};
        cfg_s[LA_DATA_W-1:0]     = err_reg_s;
        for (int k = 1; k < REG_NUM; k++) begin
            regs_all_s[k]                      = regs_q[k];
            cfg_s[k*LA_DATA_W +: LA_DATA_W]    = regs_q[k];
        end
    end

    assign ov_cfg_regs = cfg_s;

    // ------------------------------------------------------------------
    // Table RAM
    // ------------------------------------------------------------------
    logic [LA_DATA_W-1:0] ram_rdata_s;

    lar_table_ram #(
        .DEPTH (TBL_DEPTH),
        .AW    (TBL_AW)
    ) u_tbl (
        .i_clk      (i_clk),
        .i_a_we     (tbl_we_s),
        .iv_a_addr  (bus.iv_addr[TBL_AW-1:0]),
        .iv_a_wdata (bus.iv_wdata),
        .ov_a_rdata (ram_rdata_s),
        .iv_b_addr  (iv_dp_tbl_addr),
        .ov_b_rdata (ov_dp_tbl_rdata)
    );

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 captures the request while the RAM read is
    // in flight, stage 2 selects the data into the output registers.
    // ------------------------------------------------------------------
    rd_stage_t s1_q;
    rd_stage_t s1_d;

    // Stage-1 next state from the accepted read.
    always_comb begin
        s1_d.vld  = rd_acc_s;
        s1_d.addr = bus.iv_addr;
        s1_d.fix  = bus.i_addr_fix;
        s1_d.ok   = in_range_s;
    end

    // Stage-1 register; reset discards any in-flight read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    logic [IDX_W-1:0]     reg_idx_s;
    logic [LA_DATA_W-1:0] reg_rdata_s;
    logic                 o_wr_q,     o_wr_d;
    logic [LA_ADDR_W-1:0] raddr_q,    raddr_d;
    logic                 addr_fix_q, addr_fix_d;
    logic [LA_DATA_W-1:0] rdata_q,    rdata_d;

    // Stage-2 data select; response fields hold their value between responses.
    always_comb begin
        reg_idx_s   = s1_q.addr[IDX_W-1:0];
        reg_rdata_s = regs_all_s[reg_idx_s];
        o_wr_d      = s1_q.vld;
        if (s1_q.vld) begin
            raddr_d    = s1_q.addr;
            addr_fix_d = s1_q.fix;
            if (!s1_q.ok) begin
                rdata_d = OOR_RDATA;
            end else if (s1_q.fix) begin
                rdata_d = reg_rdata_s;
            end else begin
                rdata_d = ram_rdata_s;
            end
        end else begin
            raddr_d    = raddr_q;
            addr_fix_d = addr_fix_q;
            rdata_d    = rdata_q;
        end
    end

    // Stage-2 output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_q     <= 1'b0;
            raddr_q    <= 19'd0;
            addr_fix_q <= 1'b0;
            rdata_q    <= 32'h0000_0000;
        end else begin
            o_wr_q     <= o_wr_d;
            raddr_q    <= raddr_d;
            addr_fix_q <= addr_fix_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.o_wr       = o_wr_q;
    assign bus.ov_raddr   = raddr_q;
    assign bus.o_addr_fix = addr_fix_q;
    assign bus.ov_rdata   = rdata_q;

endmodule

// File: tb/tb_local_access_responder.sv
// Scoreboard bench for local_access_responder. Reads push their expected
// response (address, region, data, arrival cycle) into a queue; a monitor
// pops and compares on every o_wr. Error-register expectations follow the
// LOCAL_ACCESS_ERR_CNT_EN build option.
module tb_local_access_responder;

    logic         clk;
    logic         rst;
    logic [511:0] cfg_regs;
    logic [7:0]   dp_addr;
    logic [31:0]  dp_rdata;

    local_access_responder_if bus();

    local_access_responder dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .bus             (bus),
        .ov_cfg_regs     (cfg_regs),
        .iv_dp_tbl_addr  (dp_addr),
        .ov_dp_tbl_rdata (dp_rdata)
    );

    typedef struct {
        logic [18:0] addr;
        logic        fix;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected error-register value for a given hand-counted error count.
    function automatic logic [31:0] ec(input int n);
`ifdef LOCAL_ACCESS_ERR_CNT_EN
        return 32'(n);
`else
        return 32'h0000_0000;
`endif
    endfunction

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && bus.o_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got response addr=%h data=%h, expected none",
                         bus.ov_raddr, bus.ov_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_addr",  32'(bus.ov_raddr),   32'(e.addr));
                chk("rsp_fix",   32'(bus.o_addr_fix), 32'(e.fix));
                chk("rsp_data",  bus.ov_rdata,        e.data);
                chk("rsp_cycle", 32'(cycle_cnt),      32'(e.cyc));
            end
        end
    end

    task automatic cyc(input logic wr, input logic rd, input logic fix,
                       input logic [18:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        bus.i_wr       = wr;
        bus.i_rd       = rd;
        bus.i_addr_fix = fix;
        bus.iv_addr    = addr;
        bus.iv_wdata   = data;
    endtask

    task automatic bwr(input logic fix, input logic [18:0] addr, input logic [31:0] data);
        cyc(1'b1, 1'b0, fix, addr, data);
    endtask

    task automatic brd(input logic fix, input logic [18:0] addr, input logic [31:0] exp);
        exp_t e;
        cyc(1'b0, 1'b1, fix, addr, 32'h0);
        e.addr = addr;
        e.fix  = fix;
        e.data = exp;
        e.cyc  = cycle_cnt + 2;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 19'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.i_wr       = 1'b0;
        bus.i_rd       = 1'b0;
        bus.i_addr_fix = 1'b0;
        bus.iv_addr    = 19'd0;
        bus.iv_wdata   = 32'h0;
        dp_addr        = 8'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_wr",   32'(bus.o_wr),       32'h0);
        chk("rst_raddr",  32'(bus.ov_raddr),   32'h0);
        chk("rst_fix",    32'(bus.o_addr_fix), 32'h0);
        chk("rst_rdata",  bus.ov_rdata,        32'h0);
        chk("rst_cfg",    32'(|cfg_regs),      32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Register write, export timing and read-after-write.
        bwr(1'b1, 19'd3, 32'hA5A5_0001);     // errors: 0
        @(negedge clk);
        chk("cfg3_write_cycle", cfg_regs[127:96], 32'h0);
        brd(1'b1, 19'd3, 32'hA5A5_0001);
        @(negedge clk);
        chk("cfg3_next_cycle", cfg_regs[127:96], 32'hA5A5_0001);
        bwr(1'b1, 19'd15, 32'hF00D_F00D);
        brd(1'b1, 19'd15, 32'hF00D_F00D);
        bwr(1'b1, 19'd16, 32'hDEAD_BEEF);    // out of range: errors 1
        @(negedge clk);
        chk("cfg15_after_oor", cfg_regs[511:480], 32'hF00D_F00D);

        // Table fill and back-to-back burst reads.
        bwr(1'b0, 19'd0,   32'h10);
        bwr(1'b0, 19'd1,   32'h11);
        bwr(1'b0, 19'd2,   32'h12);
        bwr(1'b0, 19'd3,   32'h13);
        bwr(1'b0, 19'd7,   32'h70);
        bwr(1'b0, 19'd44,  32'h44);
        bwr(1'b0, 19'd255, 32'hFF);
        brd(1'b0, 19'd0,   32'h10);
        brd(1'b0, 19'd1,   32'h11);
        brd(1'b0, 19'd2,   32'h12);
        brd(1'b0, 19'd3,   32'h13);
        brd(1'b0, 19'd255, 32'hFF);
        bwr(1'b0, 19'd8,   32'h55);
        brd(1'b0, 19'd8,   32'h55);

        // Out-of-range reads and the error register.
        brd(1'b1, 19'd20,  32'h0);           // errors 2
        brd(1'b0, 19'd300, 32'h0);           // errors 3
        brd(1'b0, 19'd256, 32'h0);           // errors 4
        brd(1'b1, 19'd0,   ec(4));
        @(negedge clk);
        chk("cfg0_errcnt", cfg_regs[31:0], ec(4));
        bwr(1'b1, 19'd0, 32'hFFFF_FFFF);     // clear: errors 0
        brd(1'b1, 19'd0, 32'h0);
        bwr(1'b0, 19'd300, 32'h0BAD);        // dropped (no alias onto 44): errors 1
        brd(1'b0, 19'd44, 32'h44);
        brd(1'b1, 19'd0,  ec(1));

        // Simultaneous write and read: write lands, read dropped.
        cyc(1'b1, 1'b1, 1'b0, 19'd5, 32'h77); // errors 2
        brd(1'b0, 19'd5, 32'h77);
        brd(1'b1, 19'd0, ec(2));
        cyc(1'b1, 1'b1, 1'b0, 19'd300, 32'h123); // two causes, +1 only: errors 3
        brd(1'b0, 19'd44, 32'h44);
        brd(1'b1, 19'd0,  ec(3));
        cyc(1'b1, 1'b1, 1'b1, 19'd0, 32'h0);  // clear wins over error: errors 0
        brd(1'b1, 19'd0, 32'h0);

        // Datapath port: old data in the write cycle, new data afterwards.
        brd(1'b0, 19'd0, 32'h10);
        bwr(1'b0, 19'd7, 32'h99);
        @(negedge clk);
        chk("dp_before_write", dp_rdata, 32'h70);
        brd(1'b0, 19'd1, 32'h11);
        @(negedge clk);
        chk("dp_write_cycle", dp_rdata, 32'h70);
        brd(1'b0, 19'd7, 32'h99);
        @(negedge clk);
        chk("dp_after_write", dp_rdata, 32'h99);
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        // Reset one cycle after a read: the read must vanish.
        cyc(1'b0, 1'b1, 1'b0, 19'd0, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        @(negedge clk);
        chk("in_rst_o_wr", 32'(bus.o_wr), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(bus.o_wr), 32'h0);
        end
        chk("post_rst_raddr", 32'(bus.ov_raddr),   32'h0);
        chk("post_rst_fix",   32'(bus.o_addr_fix), 32'h0);
        chk("post_rst_rdata", bus.ov_rdata,        32'h0);
        chk("post_rst_cfg",   32'(|cfg_regs),      32'h0);
        brd(1'b1, 19'd3, 32'h0);
        brd(1'b0, 19'd0, 32'h10);
        idle(4);
        chk("queue_drained_end", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
